pe_triple_feeder: RTL and testbench

- Initiator side of the PE reducer interface.
- Accepts a stream of sparse nonzero entries (3-D address, weight, activation), one per handshake, and packs them into triples.
- Drives each triple to the PE reducer with a one-cycle start pulse and holds it stable until the reducer's finish returns.
- Handles frame tails shorter than 3 entries by padding with zero-product slots that merge into the last real address.

---
 rtl/pe_triple_feeder.sv | 133 +++++++++++++
 tb/tb_pe_triple_feeder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_triple_feeder.sv
// Packs a stream of sparse entries into address/weight/activation triples for the PE reducer.
// Optional build macro PE_FEEDER_ZERO_SKIP_EN drops zero-product entries instead of issuing them.
module pe_triple_feeder #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3*ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]       i_w,
    input  logic [DATA_W-1:0]       i_ia,
    input  logic                    i_last,
    output logic                    o_pe_start,
    output logic [3*3*ADDR_W-1:0]   o_addr,
    output logic [3*DATA_W-1:0]     o_w,
    output logic [3*DATA_W-1:0]     o_ia,
    input  logic                    i_pe_finish,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [CNT_W-1:0]        o_count
);

    localparam int unsigned AW3 = 3 * ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT, S_DONE} state_e;

    state_e             state_q;
    logic [1:0]         k_q;
    logic               last_q;
    logic [CNT_W-1:0]   count_q;
    logic [AW3-1:0]     addr_q [3];
    logic [DATA_W-1:0]  w_q    [3];
    logic [DATA_W-1:0]  ia_q   [3];

    logic xfer;
    logic skip;

    assign xfer = i_valid && (state_q == S_FILL);

`ifdef PE_FEEDER_ZERO_SKIP_EN
    assign skip = (i_w == '0) || (i_ia == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            last_q  <= 1'b0;
            count_q <= '0;
            for (int j = 0; j < 3; j++) begin
                addr_q[j] <= '0;
                w_q[j]    <= '0;
                ia_q[j]   <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_FILL;
                        k_q     <= 2'd0;
                        count_q <= '0;
                        last_q  <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (xfer && !skip) begin
                        // Slots past a tail entry repeat its address with a zero product so the
                        // reducer merges them into the last real address.
                        for (int j = 0; j < 3; j++) begin
                            if (2'(j) == k_q) begin
                                addr_q[j] <= i_addr;
                                w_q[j]    <= i_w;
                                ia_q[j]   <= i_ia;
                            end else if ((2'(j) > k_q) && i_last) begin
                                addr_q[j] <= i_addr;
                                w_q[j]    <= '0;
                                ia_q[j]   <= '0;
                            end
                        end
                        k_q <= k_q + 2'd1;
                        if (i_last || (k_q == 2'd2)) begin
                            state_q <= S_START;
                            last_q  <= i_last;
                        end
                    end
`ifdef PE_FEEDER_ZERO_SKIP_EN
                    else if (xfer && i_last) begin
                        last_q <= 1'b1;
                        if (k_q != 2'd0) begin
                            for (int j = 0; j < 3; j++) begin
                                if (2'(j) >= k_q) begin
                                    addr_q[j] <= addr_q[k_q - 2'd1];
                                    w_q[j]    <= '0;
                                    ia_q[j]   <= '0;
                                end
                            end
                            state_q <= S_START;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
`endif
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_pe_finish) begin
                        if (count_q != '1) count_q <= count_q + 1'b1;
                        k_q     <= 2'd0;
                        state_q <= last_q ? S_DONE : S_FILL;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = (state_q == S_FILL);
    assign o_pe_start = (state_q == S_START);
    assign o_done     = (state_q == S_DONE);
    assign o_busy     = (state_q != S_IDLE);
    assign o_count    = count_q;
    assign o_addr     = {addr_q[2], addr_q[1], addr_q[0]};
    assign o_w        = {w_q[2], w_q[1], w_q[0]};
    assign o_ia       = {ia_q[2], ia_q[1], ia_q[0]};

endmodule

// File: tb/tb_pe_triple_feeder.sv
// Directed self-checking bench for pe_triple_feeder; the reducer's finish is driven by hand.
module tb_pe_triple_feeder;

    localparam int AW = 7;
    localparam int DW = 16;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              valid = 1'b0;
    logic              ready;
    logic [3*AW-1:0]   addr = '0;
    logic [DW-1:0]     w = '0;
    logic [DW-1:0]     ia = '0;
    logic              last = 1'b0;
    logic              pe_start;
    logic [9*AW-1:0]   o_addr;
    logic [3*DW-1:0]   o_w;
    logic [3*DW-1:0]   o_ia;
    logic              pe_finish = 1'b0;
    logic              busy;
    logic              done;
    logic [CW-1:0]     count;

    int checks = 0;
    int errors = 0;
    int start_seen = 0;
    int done_seen = 0;

    always #5 clk = ~clk;

    pe_triple_feeder dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_addr      (addr),
        .i_w         (w),
        .i_ia        (ia),
        .i_last      (last),
        .o_pe_start  (pe_start),
        .o_addr      (o_addr),
        .o_w         (o_w),
        .o_ia        (o_ia),
        .i_pe_finish (pe_finish),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_start) start_seen++;
            if (done) done_seen++;
        end
    end

    function automatic logic [3*AW-1:0] mk(input int z, input int y, input int x);
        return {AW'(z), AW'(y), AW'(x)};
    endfunction

    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts and ends on a falling edge; the transfer happens on the rising edge in between.
    task automatic push(input logic [3*AW-1:0] a, input int wv, input int iav, input logic l);
        for (int t = 0; t < 20 && !ready; t++) @(negedge clk);
        if (!ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: o_ready=%0b required 1", ready);
            return;
        end
        valid = 1'b1; addr = a; w = DW'(wv); ia = DW'(iav); last = l;
        @(negedge clk);
        valid = 1'b0; last = 1'b0;
    endtask

    // Entered in S_START; stays in S_WAIT for n cycles, finish raised in the last one.
    task automatic finish_triple(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if ({ready, pe_start, busy} !== 3'b001) begin
                errors++;
                $display("FAIL wait_state: ready/start/busy=%b required 001", {ready, pe_start, busy});
            end
        end
        pe_finish = 1'b1;
        @(negedge clk);
        pe_finish = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0; pe_finish = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ready, pe_start, done, busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready/start/done/busy=%b required 0000",
                     {ready, pe_start, done, busy});
        end
        checks++;
        if ({o_addr, o_w, o_ia, count} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h w=%h ia=%h count=%0d required 0",
                     o_addr, o_w, o_ia, count);
        end
    endtask

    task automatic test_basic();
        start_frame();
        push(mk(0, 0, 1), 2, 5, 1'b0);
        push(mk(0, 0, 2), 3, 5, 1'b0);
        push(mk(0, 0, 3), 4, 5, 1'b1);
        checks++;
        if (pe_start !== 1'b1) begin
            errors++; $display("FAIL basic_start: o_pe_start=%b required 1", pe_start);
        end
        checks++;
        if (o_addr !== {mk(0, 0, 3), mk(0, 0, 2), mk(0, 0, 1)}) begin
            errors++; $display("FAIL basic_addr: o_addr=%h required %h", o_addr,
                               {mk(0, 0, 3), mk(0, 0, 2), mk(0, 0, 1)});
        end
        checks++;
        if ({o_w, o_ia} !== {16'd4, 16'd3, 16'd2, 16'd5, 16'd5, 16'd5}) begin
            errors++; $display("FAIL basic_data: o_w=%h o_ia=%h required 000400030002/000500050005",
                               o_w, o_ia);
        end
        finish_triple(1);
        checks++;
        if ({done, count} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL basic_done: o_done=%b o_count=%0d required 1/1", done, count);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, count} !== {2'b00, 16'd1}) begin
            errors++; $display("FAIL basic_idle: done=%b busy=%b count=%0d required 0/0/1",
                               done, busy, count);
        end
    endtask

    task automatic test_back_to_back();
        int s0, d0;
        s0 = start_seen; d0 = done_seen;
        start_frame();
        for (int i = 0; i < 3; i++) push(mk(0, 1, i), i + 1, 2, 1'b0);
        checks++;
        if (pe_start !== 1'b1) begin
            errors++; $display("FAIL b2b_start1: o_pe_start=%b required 1", pe_start);
        end
        finish_triple(2);
        checks++;
        if ({ready, count} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL b2b_refill: ready=%b count=%0d required 1/1", ready, count);
        end
        for (int i = 3; i < 6; i++) push(mk(0, 1, i), i + 1, 2, i == 5);
        checks++;
        if ({pe_start, o_w} !== {1'b1, 16'd6, 16'd5, 16'd4}) begin
            errors++; $display("FAIL b2b_start2: start=%b o_w=%h required 1/000600050004",
                               pe_start, o_w);
        end
        finish_triple(1);
        checks++;
        if ({done, count} !== {1'b1, 16'd2}) begin
            errors++; $display("FAIL b2b_done: o_done=%b o_count=%0d required 1/2", done, count);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ((start_seen - s0) != 2 || (done_seen - d0) != 1) begin
            errors++; $display("FAIL b2b_pulses: starts=%0d dones=%0d required 2/1",
                               start_seen - s0, done_seen - d0);
        end
    endtask

    task automatic test_tail_pad();
        start_frame();
        for (int i = 0; i < 3; i++) push(mk(2, 2, i), 9, 9, 1'b0);
        finish_triple(1);
        push(mk(1, 2, 3), 7, 8, 1'b1);
        checks++;
        if (o_addr !== {mk(1, 2, 3), mk(1, 2, 3), mk(1, 2, 3)}) begin
            errors++; $display("FAIL pad_addr: o_addr=%h required %h", o_addr,
                               {mk(1, 2, 3), mk(1, 2, 3), mk(1, 2, 3)});
        end
        checks++;
        if ({o_w, o_ia} !== {16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd8}) begin
            errors++; $display("FAIL pad_data: o_w=%h o_ia=%h required 000000000007/000000000008",
                               o_w, o_ia);
        end
        finish_triple(1);
        checks++;
        if ({done, count} !== {1'b1, 16'd2}) begin
            errors++; $display("FAIL pad_done: o_done=%b o_count=%0d required 1/2", done, count);
        end
        @(negedge clk);
    endtask

    task automatic test_stray();
        start_frame();
        push(mk(0, 3, 1), 1, 1, 1'b0);
        pe_finish = 1'b1; start = 1'b1;
        @(negedge clk);
        pe_finish = 1'b0; start = 1'b0;
        checks++;
        if ({ready, pe_start, busy, count} !== {3'b101, 16'd0}) begin
            errors++; $display("FAIL stray_ignored: ready/start/busy=%b count=%0d required 101/0",
                               {ready, pe_start, busy}, count);
        end
        push(mk(0, 3, 2), 2, 1, 1'b0);
        push(mk(0, 3, 3), 3, 1, 1'b1);
        checks++;
        if ({pe_start, o_w} !== {1'b1, 16'd3, 16'd2, 16'd1}) begin
            errors++; $display("FAIL stray_slots: start=%b o_w=%h required 1/000300020001",
                               pe_start, o_w);
        end
        finish_triple(1);
        checks++;
        if (count !== 16'd1) begin
            errors++; $display("FAIL stray_count: o_count=%0d required 1", count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        start_frame();
        for (int i = 0; i < 3; i++) push(mk(3, 0, i), 4, 4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, pe_start, done, busy, o_addr, o_w, o_ia, count} !== '0) begin
            errors++; $display("FAIL rst_wait: ctrl=%b addr=%h w=%h count=%0d required all 0",
                               {ready, pe_start, done, busy}, o_addr, o_w, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();
        push(mk(0, 0, 7), 1, 2, 1'b0);
        push(mk(0, 0, 8), 3, 4, 1'b0);
        push(mk(0, 0, 9), 5, 6, 1'b1);
        checks++;
        if ({pe_start, o_w, o_ia} !== {1'b1, 16'd5, 16'd3, 16'd1, 16'd6, 16'd4, 16'd2}) begin
            errors++; $display("FAIL rst_clean: start=%b o_w=%h o_ia=%h", pe_start, o_w, o_ia);
        end
        finish_triple(1);
        checks++;
        if ({done, count} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL rst_done: o_done=%b o_count=%0d required 1/1", done, count);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_entries();
`ifdef PE_FEEDER_ZERO_SKIP_EN
        int s0;
        start_frame();
        push(mk(0, 0, 1), 0, 1, 1'b0);
        push(mk(0, 0, 2), 5, 1, 1'b0);
        push(mk(0, 0, 3), 0, 1, 1'b0);
        push(mk(0, 0, 4), 6, 1, 1'b0);
        push(mk(0, 0, 5), 9, 1, 1'b1);
        checks++;
        if ({pe_start, o_w} !== {1'b1, 16'd9, 16'd6, 16'd5}) begin
            errors++; $display("FAIL zskip_triple: start=%b o_w=%h required 1/000900060005",
                               pe_start, o_w);
        end
        finish_triple(1);
        checks++;
        if ({done, count} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL zskip_done: o_done=%b o_count=%0d required 1/1", done, count);
        end
        @(negedge clk);
        s0 = start_seen;
        start_frame();
        push(mk(1, 1, 1), 0, 3, 1'b1);
        checks++;
        if ({done, pe_start} !== 2'b10) begin
            errors++; $display("FAIL zskip_lone: done/start=%b required 10", {done, pe_start});
        end
        @(negedge clk);
        checks++;
        if ({busy, count} !== {1'b0, 16'd0} || start_seen != s0) begin
            errors++; $display("FAIL zskip_noissue: busy=%b count=%0d starts=%0d required 0/0/0",
                               busy, count, start_seen - s0);
        end
`else
        start_frame();
        push(mk(0, 1, 0), 0, 3, 1'b1);
        checks++;
        if ({pe_start, o_w, o_ia} !== {1'b1, 48'd0, 16'd0, 16'd0, 16'd3}) begin
            errors++; $display("FAIL zero_issued: start=%b o_w=%h o_ia=%h", pe_start, o_w, o_ia);
        end
        checks++;
        if (o_addr !== {mk(0, 1, 0), mk(0, 1, 0), mk(0, 1, 0)}) begin
            errors++; $display("FAIL zero_addr: o_addr=%h", o_addr);
        end
        finish_triple(1);
        checks++;
        if ({done, count} !== {1'b1, 16'd1}) begin
            errors++; $display("FAIL zero_done: o_done=%b o_count=%0d required 1/1", done, count);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_tail_pad();
        test_stray();
        test_reset_in_wait();
        test_zero_entries();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
